// File: rtl/vlc_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// vlc_seq_pkg : shared state encodings and constants for the VLC frame sequencer
// Rev 1.0
// ============================================================================
package vlc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_GAP     = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_t;

   localparam int FRAME_CNT_W_DEF = 16;
   // num_frames value selecting an endless run
   localparam int CONTINUOUS      = 0;

endpackage
`default_nettype wire

// File: rtl/vlc_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// vlc_frame_sequencer_if : host control and datapath gating bundle
// Rev 1.0
// ============================================================================
interface vlc_frame_sequencer_if #(
   parameter int CNT_W       = 32,
   parameter int FRAME_CNT_W = vlc_seq_pkg::FRAME_CNT_W_DEF
);
   logic                   clk_en_i;
   logic                   start_i;
   logic                   stop_i;
   logic                   abort_i;
   logic [FRAME_CNT_W-1:0] num_frames_i;
   logic                   valid_o;
   logic                   sof_o;
   logic                   eof_o;
   logic [CNT_W-1:0]       beat_idx_o;
   logic [FRAME_CNT_W-1:0] frame_idx_o;
   logic                   busy_o;
   logic                   done_o;

   modport master (
      output clk_en_i, start_i, stop_i, abort_i, num_frames_i,
      input  valid_o, sof_o, eof_o, beat_idx_o, frame_idx_o, busy_o, done_o
   );

   modport slave (
      input  clk_en_i, start_i, stop_i, abort_i, num_frames_i,
      output valid_o, sof_o, eof_o, beat_idx_o, frame_idx_o, busy_o, done_o
   );
endinterface
`default_nettype wire

// File: rtl/vlc_frame_sequencer_tick_counter.sv
`default_nettype none
// ============================================================================
// vlc_tick_counter : strobe-gated up-counter, wraps to 0 after TERMINAL
// Rev 1.0
// ============================================================================
module vlc_tick_counter #(
   parameter int             W        = 32,
   parameter logic [W-1:0]   TERMINAL = '0
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         clr_i,
   input  wire logic         en_i,
   output logic [W-1:0]      count_o,
   output logic              tc_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q == TERMINAL) ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == TERMINAL);
endmodule
`default_nettype wire

// File: rtl/vlc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// vlc_frame_sequencer : frames valid/sof/eof as FRAME_LEN beats + GAP_LEN gap
// Rev 1.0
// ============================================================================
module vlc_frame_sequencer
   import vlc_seq_pkg::*;
#(
   parameter int FRAME_LEN   = 224,
   parameter int GAP_LEN     = 16,
   parameter int CNT_W       = 32,
   parameter int FRAME_CNT_W = FRAME_CNT_W_DEF
) (
   input  wire logic              clk,
   input  wire logic              reset,
   vlc_frame_sequencer_if.slave   bus
);
   localparam logic [CNT_W-1:0] C_BEAT_TERM = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] C_GAP_TERM  = CNT_W'(GAP_LEN - 1);

   seq_state_t             state_q;
   logic [FRAME_CNT_W-1:0] frame_q;
   logic [FRAME_CNT_W-1:0] num_frames_q;
   logic                   stop_pending_q;

   logic [CNT_W-1:0]       w_beat;
   logic                   w_beat_tc;
   logic [CNT_W-1:0]       w_unused_gap_cnt;
   logic                   w_gap_tc;
   logic                   w_valid;
   logic                   w_stop_eff;
   logic                   w_last_frame;

   assign w_valid      = (state_q == ST_PAYLOAD) & bus.clk_en_i & ~bus.abort_i;
   // A stop arriving on the eof cycle itself must still end the run
   assign w_stop_eff   = stop_pending_q | bus.stop_i;
   assign w_last_frame = (num_frames_q != FRAME_CNT_W'(CONTINUOUS)) &&
                         (frame_q == num_frames_q - FRAME_CNT_W'(1));

   vlc_tick_counter #(.W(CNT_W), .TERMINAL(C_BEAT_TERM)) u_beat_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (bus.abort_i | (state_q == ST_IDLE)),
      .en_i    (w_valid),
      .count_o (w_beat),
      .tc_o    (w_beat_tc)
   );

   vlc_tick_counter #(.W(CNT_W), .TERMINAL(C_GAP_TERM)) u_gap_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (bus.abort_i | (state_q != ST_GAP)),
      .en_i    ((state_q == ST_GAP) & bus.clk_en_i),
      .count_o (w_unused_gap_cnt),
      .tc_o    (w_gap_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         frame_q        <= '0;
         num_frames_q   <= '0;
         stop_pending_q <= 1'b0;
      end else if (bus.abort_i) begin
         state_q        <= ST_IDLE;
         frame_q        <= '0;
         stop_pending_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            stop_pending_q <= 1'b0;
         end else if (bus.stop_i) begin
            stop_pending_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  num_frames_q <= bus.num_frames_i;
                  frame_q      <= '0;
                  state_q      <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (bus.clk_en_i && w_beat_tc) begin
                  frame_q <= frame_q + FRAME_CNT_W'(1);
                  if (w_last_frame || w_stop_eff) begin
                     state_q <= ST_DONE;
                  end else if (GAP_LEN != 0) begin
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (w_stop_eff) begin
                  state_q <= ST_DONE;
               end else if (bus.clk_en_i && w_gap_tc) begin
                  state_q <= ST_PAYLOAD;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.valid_o     = w_valid;
   assign bus.sof_o       = w_valid & (w_beat == '0);
   assign bus.eof_o       = w_valid & w_beat_tc;
   assign bus.beat_idx_o  = w_beat;
   assign bus.frame_idx_o = frame_q;
   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.done_o      = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_vlc_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_vlc_frame_sequencer : directed self-checking bench for vlc_frame_sequencer
// Rev 1.0
// ============================================================================
module tb_vlc_frame_sequencer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vlc_frame_sequencer_if #(.CNT_W(32), .FRAME_CNT_W(16)) ifa ();
   vlc_frame_sequencer_if #(.CNT_W(8),  .FRAME_CNT_W(4))  ifb ();

   vlc_frame_sequencer #(.FRAME_LEN(4), .GAP_LEN(2), .CNT_W(32), .FRAME_CNT_W(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   vlc_frame_sequencer #(.FRAME_LEN(1), .GAP_LEN(0), .CNT_W(8), .FRAME_CNT_W(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int nv, nsof, neof, nd, done_k, off, post, nse, nbusy;
   int sof_k [4];
   int eof_k [4];
   int sof_fr [4];

   // {valid, sof, eof, busy, done} per cycle after start, FRAME_LEN=4 GAP_LEN=2 two frames
   logic [4:0] exp_t1 [12] = '{5'b11010, 5'b10010, 5'b10010, 5'b10110,
                               5'b00010, 5'b00010,
                               5'b11010, 5'b10010, 5'b10010, 5'b10110,
                               5'b00011, 5'b00000};

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [4:0] sta_a();
      return {ifa.valid_o, ifa.sof_o, ifa.eof_o, ifa.busy_o, ifa.done_o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      nv = 0; nsof = 0; neof = 0; nd = 0; done_k = -1; off = 0; post = 0; nse = 0; nbusy = 0;
      for (int i = 0; i < 4; i++) begin
         sof_k[i] = -1; eof_k[i] = -1; sof_fr[i] = -1;
      end
   endtask

   // Record events on dut_a at cycle k (sampled away from the clock edge)
   task automatic observe_a(input int k);
      if (ifa.valid_o) begin
         nv++;
         if (!ifa.clk_en_i) off++;
         if (done_k >= 0) post++;
      end
      if (ifa.sof_o) begin
         if (nsof < 4) begin
            sof_k[nsof]  = k;
            sof_fr[nsof] = int'(ifa.frame_idx_o);
         end
         nsof++;
      end
      if (ifa.eof_o) begin
         if (neof < 4) eof_k[neof] = k;
         neof++;
      end
      if (ifa.done_o) begin
         nd++;
         done_k = k;
      end
   endtask

   initial begin
      ifa.clk_en_i = 1'b1; ifa.start_i = 1'b0; ifa.stop_i = 1'b0; ifa.abort_i = 1'b0;
      ifa.num_frames_i = '0;
      ifb.clk_en_i = 1'b1; ifb.start_i = 1'b0; ifb.stop_i = 1'b0; ifb.abort_i = 1'b0;
      ifb.num_frames_i = '0;
      #1;
      chk("reset_status", {27'd0, sta_a()}, 64'd0);
      chk("reset_frame_idx", ifa.frame_idx_o, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();

      // Test 1: two frames, clk_en held high
      clr_stats();
      ifa.num_frames_i = 16'd2;
      ifa.start_i = 1'b1;
      #1;
      chk("t1_c0", {59'd0, sta_a()}, 64'd0);
      step();
      ifa.start_i = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         #1;
         chk($sformatf("t1_c%0d", c), {59'd0, sta_a()}, {59'd0, exp_t1[c-1]});
         if (ifa.valid_o) nv++;
         if (c == 7)  chk("t1_frame_c7", ifa.frame_idx_o, 64'd1);
         if (c == 12) chk("t1_frame_end", ifa.frame_idx_o, 64'd2);
         step();
      end
      chk("t1_valid_total", nv, 64'd8);

      // Test 2: clk_en every third cycle
      clr_stats();
      for (int k = 0; k <= 40; k++) begin
         ifa.clk_en_i = (k % 3 == 0);
         ifa.start_i  = (k == 0);
         #1;
         observe_a(k);
         step();
      end
      ifa.clk_en_i = 1'b1;
      chk("t2_valid_total", nv, 64'd8);
      chk("t2_off_strobe_valid", off, 64'd0);
      chk("t2_sof0", sof_k[0], 64'd3);
      chk("t2_eof0", eof_k[0], 64'd12);
      chk("t2_sof1", sof_k[1], 64'd21);
      chk("t2_eof1", eof_k[1], 64'd30);
      chk("t2_done_cycle", done_k, 64'd31);
      chk("t2_busy_end", ifa.busy_o, 64'd0);

      // Test 3: continuous, graceful stop during frame 2 beat 1
      clr_stats();
      ifa.num_frames_i = 16'd0;
      for (int k = 0; k <= 26; k++) begin
         ifa.start_i = (k == 0);
         ifa.stop_i  = (k == 14);
         #1;
         if (k == 14) begin
            chk("t3_stop_frame", ifa.frame_idx_o, 64'd2);
            chk("t3_stop_beat", ifa.beat_idx_o, 64'd1);
         end
         observe_a(k);
         step();
      end
      ifa.stop_i = 1'b0;
      chk("t3_sof_count", nsof, 64'd3);
      chk("t3_sof_frame0", sof_fr[0], 64'd0);
      chk("t3_sof_frame1", sof_fr[1], 64'd1);
      chk("t3_sof_frame2", sof_fr[2], 64'd2);
      chk("t3_eof_count", neof, 64'd3);
      chk("t3_done_count", nd, 64'd1);
      chk("t3_done_cycle", done_k, 64'd17);
      chk("t3_valid_after_done", post, 64'd0);
      chk("t3_frame_final", ifa.frame_idx_o, 64'd3);

      // Test 4: abort at beat 2, then restart
      clr_stats();
      ifa.num_frames_i = 16'd1;
      ifa.start_i = 1'b1;
      step();
      ifa.start_i = 1'b0;
      step();
      step();
      ifa.abort_i = 1'b1;
      #1;
      chk("t4_abort_beat", ifa.beat_idx_o, 64'd2);
      chk("t4_abort_valid", ifa.valid_o, 64'd0);
      step();
      ifa.abort_i = 1'b0;
      #1;
      chk("t4_busy_after", ifa.busy_o, 64'd0);
      chk("t4_beat_cleared", ifa.beat_idx_o, 64'd0);
      for (int k = 0; k < 6; k++) begin
         #1;
         observe_a(k);
         step();
      end
      chk("t4_no_done_no_valid", nd + nv, 64'd0);
      ifa.start_i = 1'b1;
      step();
      ifa.start_i = 1'b0;
      #1;
      chk("t4_restart", {ifa.valid_o, ifa.sof_o, ifa.frame_idx_o, ifa.beat_idx_o}, 64'h3_0000_0000_0000);
      for (int k = 0; k < 6; k++) step();
      chk("t4_restart_end_busy", ifa.busy_o, 64'd0);

      // Test 5: asynchronous reset mid-gap
      ifa.num_frames_i = 16'd0;
      ifa.start_i = 1'b1;
      step();
      ifa.start_i = 1'b0;
      for (int k = 1; k < 5; k++) step();
      #1;
      chk("t5_in_gap", {ifa.busy_o, ifa.valid_o, ifa.frame_idx_o}, 64'h2_0001);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_clear", {sta_a(), ifa.frame_idx_o, ifa.beat_idx_o}, 64'd0);
      step();
      step();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (ifa.busy_o) nbusy++;
         step();
      end
      chk("t5_idle_after_release", nbusy, 64'd0);

      // Test 6a: start while busy is ignored
      clr_stats();
      ifa.num_frames_i = 16'd2;
      for (int k = 0; k <= 12; k++) begin
         ifa.start_i = (k == 0) || (k == 3);
         if (k == 3) ifa.num_frames_i = 16'd5;
         #1;
         observe_a(k);
         step();
      end
      ifa.start_i = 1'b0;
      chk("t6_done_cycle", done_k, 64'd11);
      chk("t6_frame_final", ifa.frame_idx_o, 64'd2);

      // Test 6b: start and abort together in IDLE
      ifa.start_i = 1'b1;
      ifa.abort_i = 1'b1;
      step();
      ifa.start_i = 1'b0;
      ifa.abort_i = 1'b0;
      #1;
      chk("t6_start_abort_busy", ifa.busy_o, 64'd0);
      step();
      chk("t6_start_abort_valid", ifa.valid_o, 64'd0);

      // Test 6c: FRAME_LEN=1, GAP_LEN=0, 4-bit frame counter wrap
      ifb.num_frames_i = 4'd0;
      ifb.start_i = 1'b1;
      step();
      ifb.start_i = 1'b0;
      nse = 0;
      for (int c = 1; c <= 17; c++) begin
         #1;
         if (ifb.valid_o && ifb.sof_o && ifb.eof_o) nse++;
         if (c == 5)  chk("t6c_frame_c5", ifb.frame_idx_o, 64'd4);
         if (c == 16) chk("t6c_frame_c16", ifb.frame_idx_o, 64'd15);
         if (c == 17) chk("t6c_wrap", {ifb.busy_o, ifb.frame_idx_o}, 64'h10);
         step();
      end
      chk("t6c_sof_eof_beats", nse, 64'd17);
      ifb.abort_i = 1'b1;
      step();
      ifb.abort_i = 1'b0;
      #1;
      chk("t6c_abort_idle", {ifb.busy_o, ifb.done_o}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
